// File: rtl/breakout_pkg.sv
// ---------------------------------------------------------------------------
// breakout_pkg
//   Shared definitions for the breakout brick wall:
//     - 6-bit {B,G,R} colour constants (2 bits per channel)
//     - row_color(): colour of a brick row, in 2-row bands that wrap every 8 bands
//     - row_points(): score value of a brick row (top rows are worth the most)
//     - idx_width(): index width helper that never returns zero
// ---------------------------------------------------------------------------
package breakout_pkg;

    localparam logic [5:0] COLOR_RED     = 6'b00_00_11;
    localparam logic [5:0] COLOR_ORANGE  = 6'b00_01_11;
    localparam logic [5:0] COLOR_YELLOW  = 6'b00_11_11;
    localparam logic [5:0] COLOR_GREEN   = 6'b00_11_00;
    localparam logic [5:0] COLOR_CYAN    = 6'b11_11_00;
    localparam logic [5:0] COLOR_BLUE    = 6'b11_00_00;
    localparam logic [5:0] COLOR_MAGENTA = 6'b11_00_11;
    localparam logic [5:0] COLOR_WHITE   = 6'b11_11_11;
    localparam logic [5:0] COLOR_CRACKED = 6'b10_10_10;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Two consecutive rows share a colour band; the band sequence repeats after eight bands.
    function automatic logic [5:0] row_color(input int row);
        case ((row >> 1) % 8)
            0:       return COLOR_RED;
            1:       return COLOR_ORANGE;
            2:       return COLOR_YELLOW;
            3:       return COLOR_GREEN;
            4:       return COLOR_CYAN;
            5:       return COLOR_BLUE;
            6:       return COLOR_MAGENTA;
            default: return COLOR_WHITE;
        endcase
    endfunction

    // Bottom row pair is worth 1 point, each pair above it one more.
    function automatic int row_points(input int row, input int num_rows);
        return 1 + ((num_rows - 1 - row) >> 1);
    endfunction

endpackage

// File: rtl/brick_field_decode.sv
// ---------------------------------------------------------------------------
// brick_field_decode
//   Purely combinational raster decode: maps the current pixel to a brick cell.
//   Ports:
//     hpos, vpos  in   current pixel column / line
//     in_field    out  pixel lies inside the brick field
//     row, col    out  brick cell under the pixel (meaningful when in_field)
//     mortar      out  pixel is on the last column or last line of its brick
// ---------------------------------------------------------------------------
module brick_field_decode
    import breakout_pkg::*;
#(
    parameter int NUM_ROWS     = 16,
    parameter int NUM_COLS     = 16,
    parameter int BRICK_W_LOG2 = 5,
    parameter int BRICK_H_LOG2 = 3,
    parameter int FIELD_X0     = 64,
    parameter int FIELD_Y0     = 48
)(
    input  logic [9:0]                     hpos,
    input  logic [8:0]                     vpos,
    output logic                           in_field,
    output logic [idx_width(NUM_ROWS)-1:0] row,
    output logic [idx_width(NUM_COLS)-1:0] col,
    output logic                           mortar
);

    localparam int ROW_W = idx_width(NUM_ROWS);
    localparam int COL_W = idx_width(NUM_COLS);
    // Two spare bits above the raster coordinate: one for headroom, one as the sign.
    localparam int DX_W  = 12;
    localparam int DY_W  = 11;
    localparam logic [DX_W-2:0] FIELD_W = (DX_W-1)'(NUM_COLS << BRICK_W_LOG2);
    localparam logic [DY_W-2:0] FIELD_H = (DY_W-1)'(NUM_ROWS << BRICK_H_LOG2);

    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;

    // Offsets relative to the field origin; pixels left of / above the field go negative
    // (top bit set) instead of wrapping around into a valid cell.
    assign dx = {2'b00, hpos} - DX_W'(FIELD_X0);
    assign dy = {2'b00, vpos} - DY_W'(FIELD_Y0);

    assign in_field = ~dx[DX_W-1] & (dx[DX_W-2:0] < FIELD_W) &
                      ~dy[DY_W-1] & (dy[DY_W-2:0] < FIELD_H);

    assign col = dx[BRICK_W_LOG2 +: COL_W];
    assign row = dy[BRICK_H_LOG2 +: ROW_W];

    // Last pixel column / last line of every brick is left dark as a mortar gap.
    assign mortar = (&dx[BRICK_W_LOG2-1:0]) | (&dy[BRICK_H_LOG2-1:0]);

endmodule

// File: rtl/brick_field_engine.sv
// ---------------------------------------------------------------------------
// brick_field_engine
//   Brick-wall controller for breakout. Holds per-brick state, paints bricks from
//   the raster position, latches the first ball/brick overlap of each frame and
//   applies it (plus any requested wall refill) at the start of vertical blanking.
//   Build option: define MULTI_HIT_EN for 2-bit bricks where the top HARD_ROWS rows
//   take two hits and show a cracked colour after the first.
//   Ports:
//     clk, rst      pixel clock, asynchronous active-high reset
//     hpos, vpos    raster position; active = display active
//     frame_pulse   one-cycle pulse at start of vertical blanking
//     ball_px       ball covers the current pixel
//     level_reload  request a full wall refill at the next frame_pulse
//     draw_brick    brick pixel at (hpos,vpos), combinational
//     brick_color   {B,G,R} colour of that pixel
//     hit_valid     one-cycle pulse when a hit is applied
//     hit_row/col   cell of the last applied hit
//     score         saturating points total
//     bricks_left   bricks still present
//     level_clear   registered, high while no bricks remain
// ---------------------------------------------------------------------------
module brick_field_engine
    import breakout_pkg::*;
#(
    parameter int NUM_ROWS     = 16,
    parameter int NUM_COLS     = 16,
    parameter int BRICK_W_LOG2 = 5,
    parameter int BRICK_H_LOG2 = 3,
    parameter int FIELD_X0     = 64,
    parameter int FIELD_Y0     = 48,
    parameter int SCORE_W      = 12,
    parameter int HARD_ROWS    = 4
)(
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [9:0]                               hpos,
    input  logic [8:0]                               vpos,
    input  logic                                     active,
    input  logic                                     frame_pulse,
    input  logic                                     ball_px,
    input  logic                                     level_reload,
    output logic                                     draw_brick,
    output logic [5:0]                               brick_color,
    output logic                                     hit_valid,
    output logic [idx_width(NUM_ROWS)-1:0]           hit_row,
    output logic [idx_width(NUM_COLS)-1:0]           hit_col,
    output logic [SCORE_W-1:0]                       score,
    output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]   bricks_left,
    output logic                                     level_clear
);

    localparam int ROW_W  = idx_width(NUM_ROWS);
    localparam int COL_W  = idx_width(NUM_COLS);
    localparam int TOTAL  = NUM_ROWS * NUM_COLS;
    localparam int LEFT_W = $clog2(TOTAL + 1);

`ifdef MULTI_HIT_EN
    localparam int CNT_W     = 2;
    localparam bit MULTI_HIT = 1'b1;
`else
    localparam int CNT_W     = 1;
    localparam bit MULTI_HIT = 1'b0;
`endif

    // Hit count a brick starts with after reset or refill.
    function automatic logic [CNT_W-1:0] full_count(input int r);
        return (MULTI_HIT && (r < HARD_ROWS)) ? CNT_W'(2) : CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] cells [NUM_ROWS][NUM_COLS];

    logic             in_field;
    logic             mortar;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CNT_W-1:0] cur_cnt;
    logic             cracked;

    logic             pend_hit;
    logic             pend_reload;
    logic [ROW_W-1:0] pend_row;
    logic [COL_W-1:0] pend_col;
    logic [CNT_W-1:0] pend_cnt;
    logic [SCORE_W:0] score_sum;
    logic [SCORE_W-1:0] score_next;

    brick_field_decode #(
        .NUM_ROWS     (NUM_ROWS),
        .NUM_COLS     (NUM_COLS),
        .BRICK_W_LOG2 (BRICK_W_LOG2),
        .BRICK_H_LOG2 (BRICK_H_LOG2),
        .FIELD_X0     (FIELD_X0),
        .FIELD_Y0     (FIELD_Y0)
    ) u_decode (
        .hpos     (hpos),
        .vpos     (vpos),
        .in_field (in_field),
        .row      (row),
        .col      (col),
        .mortar   (mortar)
    );

    // Painting is a straight lookup of the registered wall at the decoded cell.
    // A brick in a hard row that is down to one hit shows the cracked colour.
    assign cur_cnt     = cells[row][col];
    assign draw_brick  = active & in_field & (cur_cnt != '0) & ~mortar;
    assign cracked     = MULTI_HIT && (int'(row) < HARD_ROWS) && (cur_cnt == CNT_W'(1));
    assign brick_color = cracked ? COLOR_CRACKED : row_color(int'(row));

    // Score for the pending hit; the spare top bit flags overflow so the total can saturate.
    assign pend_cnt   = cells[pend_row][pend_col];
    assign score_sum  = {1'b0, score} + (SCORE_W+1)'(row_points(int'(pend_row), NUM_ROWS));
    assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Wall state only changes on frame_pulse (vblank), so a frame is never painted
    // half-updated. During the visible frame we just collect the first overlap and any
    // reload request. At frame_pulse a pending reload beats a pending hit, and a reload
    // requested in the frame_pulse cycle itself is carried into the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++)
                    cells[r][c] <= full_count(r);
            pend_hit    <= 1'b0;
            pend_reload <= 1'b0;
            pend_row    <= '0;
            pend_col    <= '0;
            hit_valid   <= 1'b0;
            hit_row     <= '0;
            hit_col     <= '0;
            score       <= '0;
            bricks_left <= LEFT_W'(TOTAL);
            level_clear <= 1'b0;
        end else begin
            hit_valid   <= 1'b0;
            level_clear <= (bricks_left == '0);
            if (frame_pulse) begin
                pend_reload <= level_reload;
                pend_hit    <= 1'b0;
                if (pend_reload) begin
                    for (int r = 0; r < NUM_ROWS; r++)
                        for (int c = 0; c < NUM_COLS; c++)
                            cells[r][c] <= full_count(r);
                    bricks_left <= LEFT_W'(TOTAL);
                    level_clear <= 1'b0;
                end else if (pend_hit && (pend_cnt != '0)) begin
                    cells[pend_row][pend_col] <= pend_cnt - CNT_W'(1);
                    hit_valid <= 1'b1;
                    hit_row   <= pend_row;
                    hit_col   <= pend_col;
                    score     <= score_next;
                    if (pend_cnt == CNT_W'(1))
                        bricks_left <= bricks_left - LEFT_W'(1);
                end
            end else begin
                if (level_reload)
                    pend_reload <= 1'b1;
                if (!pend_hit && draw_brick && ball_px) begin
                    pend_hit <= 1'b1;
                    pend_row <= row;
                    pend_col <= col;
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_field_engine.sv
// ---------------------------------------------------------------------------
// tb_brick_field_engine
//   Directed bench for brick_field_engine. Stimulus tasks push the expected hit
//   result into a queue; a monitor pops and compares on every hit_valid pulse.
//   Raster position is driven directly to the pixels of interest rather than
//   sweeping full frames. Honours MULTI_HIT_EN like the design.
// ---------------------------------------------------------------------------
module tb_brick_field_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic       active;
    logic       frame_pulse;
    logic       ball_px;
    logic       level_reload;
    logic       draw_brick;
    logic [5:0] brick_color;
    logic       hit_valid;
    logic [3:0] hit_row;
    logic [3:0] hit_col;
    logic [11:0] score;
    logic [8:0] bricks_left;
    logic       level_clear;

    always #5 clk = ~clk;

    brick_field_engine dut (
        .clk          (clk),
        .rst          (rst),
        .hpos         (hpos),
        .vpos         (vpos),
        .active       (active),
        .frame_pulse  (frame_pulse),
        .ball_px      (ball_px),
        .level_reload (level_reload),
        .draw_brick   (draw_brick),
        .brick_color  (brick_color),
        .hit_valid    (hit_valid),
        .hit_row      (hit_row),
        .hit_col      (hit_col),
        .score        (score),
        .bricks_left  (bricks_left),
        .level_clear  (level_clear)
    );

    typedef struct {
        int row;
        int col;
        int score;
        int left;
    } hit_t;

    hit_t exp_q[$];
    hit_t mon_e;
    int   total_checks = 0;
    int   bad_checks   = 0;
    int   model_cnt [16][16];
    int   exp_score;
    int   exp_left;

    function automatic int full_cnt(input int r);
`ifdef MULTI_HIT_EN
        return (r < 4) ? 2 : 1;
`else
        return (r < 0) ? 2 : 1;
`endif
    endfunction

    function automatic int pts(input int r);
        return 1 + (15 - r) / 2;
    endfunction

    task automatic check_output(input string name, input int actual, input int required);
        total_checks++;
        if (actual != required) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    // Every applied hit must have been announced by the stimulus side.
    always @(negedge clk) begin
        if (rst === 1'b0 && hit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_hit_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("hit_row", int'(hit_row), mon_e.row);
                check_output("hit_col", int'(hit_col), mon_e.col);
                check_output("hit_score", int'(score), mon_e.score);
                check_output("hit_bricks_left", int'(bricks_left), mon_e.left);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_refill();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                model_cnt[r][c] = full_cnt(r);
        exp_left = 256;
    endtask

    task automatic model_hit(input int r, input int c);
        hit_t e;
        model_cnt[r][c]--;
        exp_score += pts(r);
        if (exp_score > 4095)
            exp_score = 4095;
        if (model_cnt[r][c] == 0)
            exp_left--;
        e.row   = r;
        e.col   = c;
        e.score = exp_score;
        e.left  = exp_left;
        exp_q.push_back(e);
    endtask

    // One cycle with the ball over the given pixel.
    task automatic apply_stimulus(input int h, input int v);
        hpos    = 10'(h);
        vpos    = 9'(v);
        active  = 1'b1;
        ball_px = 1'b1;
        tick();
        active  = 1'b0;
        ball_px = 1'b0;
    endtask

    // Frame boundary; returns #1 after the apply edge.
    task automatic frame_end(input bit expect_hit, input int r, input int c, input bit reload_now);
        if (expect_hit)
            model_hit(r, c);
        frame_pulse  = 1'b1;
        level_reload = reload_now;
        tick();
        frame_pulse  = 1'b0;
        level_reload = 1'b0;
    endtask

    task automatic check_pixel(input string name, input int h, input int v, input int required);
        hpos   = 10'(h);
        vpos   = 9'(v);
        active = 1'b1;
        #1;
        check_output(name, int'(draw_brick), required);
        active = 1'b0;
    endtask

    task automatic check_color(input string name, input int h, input int v, input int required);
        hpos   = 10'(h);
        vpos   = 9'(v);
        active = 1'b1;
        #1;
        check_output(name, int'(brick_color), required);
        active = 1'b0;
    endtask

    task automatic check_state(input string name);
        check_output({name, "_score"}, int'(score), exp_score);
        check_output({name, "_left"}, int'(bricks_left), exp_left);
    endtask

    task automatic clear_wall();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                while (model_cnt[r][c] != 0) begin
                    apply_stimulus(64 + c * 32 + 4, 48 + r * 8 + 2);
                    frame_end(1'b1, r, c, 1'b0);
                end
    endtask

    initial begin
        rst = 1'b1;
        hpos = '0; vpos = '0; active = 1'b0; frame_pulse = 1'b0;
        ball_px = 1'b0; level_reload = 1'b0;
        exp_score = 0;
        model_refill();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_output("reset_bricks_left", int'(bricks_left), 256);
        check_output("reset_score", int'(score), 0);
        check_output("reset_level_clear", int'(level_clear), 0);
        check_output("reset_hit_valid", int'(hit_valid), 0);
        check_output("reset_hit_row", int'(hit_row), 0);
        check_output("reset_hit_col", int'(hit_col), 0);

        // Decode boundaries and colours on a full wall
        check_pixel("px_64_48", 64, 48, 1);
        check_pixel("px_95_48_mortar", 95, 48, 0);
        check_pixel("px_63_48_left", 63, 48, 0);
        check_pixel("px_64_47_above", 64, 47, 0);
        check_pixel("px_64_55_mortar", 64, 55, 0);
        check_pixel("px_544_168", 544, 168, 1);
        check_pixel("px_576_48_right", 576, 48, 0);
        check_pixel("px_64_176_below", 64, 176, 0);
        check_color("color_row0", 64, 48, 6'b000011);
        check_color("color_row2", 64, 64, 6'b000111);
        check_color("color_row15", 544, 168, 6'b111111);
        frame_end(1'b0, 0, 0, 1'b0);
        tick();
        check_output("idle_frame_left", int'(bricks_left), 256);

        // Single hit at (100,60) -> row 1, col 1
        apply_stimulus(100, 60);
        frame_end(1'b1, 1, 1, 1'b0);
        tick();
`ifndef MULTI_HIT_EN
        check_output("first_hit_score", int'(score), 8);
        check_output("first_hit_left", int'(bricks_left), 255);
`endif
        check_pixel("px_100_60_after_hit", 100, 60, model_cnt[1][1] != 0 ? 1 : 0);

        // Two overlaps in one frame: only the first (row 1) applies
        apply_stimulus(132, 60);
        apply_stimulus(132, 90);
        frame_end(1'b1, 1, 2, 1'b0);
        apply_stimulus(132, 90);
        frame_end(1'b1, 5, 2, 1'b0);
        tick();
        check_pixel("px_132_90_after_hit", 132, 90, 0);
        check_state("two_overlap");

        // Reload and pending hit in the same frame: reload wins, no hit_valid
        level_reload = 1'b1;
        tick();
        level_reload = 1'b0;
        apply_stimulus(164, 60);
        model_refill();
        frame_end(1'b0, 0, 0, 1'b0);
        tick();
        check_state("reload_vs_hit");
        check_pixel("px_100_60_refilled", 100, 60, 1);

        // Reload raised in the frame_pulse cycle applies one frame later
        apply_stimulus(100, 60);
        frame_end(1'b1, 1, 1, 1'b1);
        tick();
        check_state("reload_in_pulse_first");
        model_refill();
        frame_end(1'b0, 0, 0, 1'b0);
        tick();
        check_state("reload_in_pulse_second");

`ifdef MULTI_HIT_EN
        // Hard brick: cracked after first hit, gone after second
        apply_stimulus(70, 50);
        frame_end(1'b1, 0, 0, 1'b0);
        tick();
        check_color("cracked_color", 70, 50, 6'b101010);
        check_pixel("cracked_present", 70, 50, 1);
        apply_stimulus(70, 50);
        frame_end(1'b1, 0, 0, 1'b0);
        tick();
        check_pixel("hard_gone", 70, 50, 0);
        check_output("hard_left", int'(bricks_left), 255);
`endif

        // Clear the wall four times; score must saturate on the way
        for (int k = 0; k < 4; k++) begin
            clear_wall();
            check_output("clear_left_zero", int'(bricks_left), 0);
            check_output("clear_level_clear_lag", int'(level_clear), 0);
            tick();
            check_output("clear_level_clear", int'(level_clear), 1);
            level_reload = 1'b1;
            tick();
            level_reload = 1'b0;
            model_refill();
            frame_end(1'b0, 0, 0, 1'b0);
            check_output("reload_level_clear", int'(level_clear), 0);
            check_state("reload_after_clear");
        end
        check_output("score_saturated", int'(score), 4095);

        // Reset mid-frame drops the latched hit
        apply_stimulus(100, 60);
        rst = 1'b1;
        #1;
        check_output("async_reset_score", int'(score), 0);
        tick();
        rst = 1'b0;
        exp_score = 0;
        model_refill();
        frame_end(1'b0, 0, 0, 1'b0);
        tick();
        check_state("after_mid_reset");
        check_pixel("px_100_60_after_reset", 100, 60, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            tick();
        if (exp_q.size() != 0)
            check_output("pending_expected_hits", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
